// File: rtl/pram_loader.sv
`default_nettype none
// ============================================================================
//  Module   : pram_loader
//  Purpose  : Writer side of the program RAM. Receives a byte stream from the
//             pads, packs byte pairs (little-endian) into DW-bit instructions
//             and writes them to the program RAM from address 0 upwards. The
//             CPU core is held while a load is in progress.
//
//  Stream   : COUNT byte N (1..DEPTH), 2N data bytes (low byte, then high
//             byte, for each word), then [CSUM byte = XOR of all data bytes].
//
//  Build option:
//    PRAM_LOADER_CSUM_EN  defined   -> trailing CSUM byte is consumed and
//                                      checked; a mismatch ends in err.
//                         undefined -> no CSUM byte; the load completes after
//                                      the write of the last word.
//
//  Ports    : clk, rst_n (async, active-low)
//             load_en              level request / abort of load mode
//             byte_valid, byte_in  pad byte stream
//             byte_ready           loader accepts byte_in this cycle
//             wr_en, wr_addr,
//             wr_data              one-cycle program RAM write port
//             cpu_hold             stall request to the core
//             done, err            load outcome, held until load_en drops
//
//  Revision : 1.0  initial release
// ============================================================================
module pram_loader #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic          byte_valid,
    input  logic [7:0]    byte_in,
    output logic          byte_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_LO    = 3'd2,
        S_HI    = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [8:0]  c_depth = 9'(DEPTH);
    localparam logic [AW:0] c_one   = {{AW{1'b0}}, 1'b1};

    state_t        r_state;
    state_t        w_next;
    logic [AW:0]   r_count;     // N, one bit wider than the address so N=DEPTH fits
    logic [AW:0]   r_idx;       // index of the next word to be written
    logic [7:0]    r_lo;
    logic          r_ready;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_data;
    logic          r_hold;
    logic          r_done;
    logic          r_err;
`ifdef PRAM_LOADER_CSUM_EN
    logic [7:0]    r_csum;
`endif

    logic          w_accept;
    logic [AW:0]   w_idx_inc;
    logic          w_last;
    logic          w_count_bad;
    logic [AW:0]   w_idx_nxt;
    logic          w_next_active;
    logic          w_ready_nxt;

    // load_en gates acceptance so that an abort wins over a simultaneous byte.
    assign w_accept    = r_ready & byte_valid & load_en;
    assign w_idx_inc   = r_idx + c_one;
    assign w_last      = (w_idx_inc == r_count);
    assign w_count_bad = (byte_in == 8'd0) || ({1'b0, byte_in} > c_depth);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (load_en) w_next = S_COUNT;
            end
            S_COUNT: begin
                if (!load_en)     w_next = S_IDLE;
                else if (w_accept) w_next = w_count_bad ? S_ERR : S_LO;
            end
            S_LO: begin
                if (!load_en)     w_next = S_IDLE;
                else if (w_accept) w_next = S_HI;
            end
            S_HI: begin
                if (!load_en) begin
                    w_next = S_IDLE;
                end else if (w_accept) begin
`ifdef PRAM_LOADER_CSUM_EN
                    w_next = w_last ? S_CSUM : S_LO;
`else
                    // Last word: wait in HI (not ready) for the cycle in which
                    // the write strobe is presented, then finish.
                    w_next = w_last ? S_HI : S_LO;
`endif
                end
`ifndef PRAM_LOADER_CSUM_EN
                else if (r_idx == r_count) begin
                    w_next = S_DONE;
                end
`endif
            end
`ifdef PRAM_LOADER_CSUM_EN
            S_CSUM: begin
                if (!load_en)      w_next = S_IDLE;
                else if (w_accept) w_next = ((r_csum ^ byte_in) == 8'd0) ? S_DONE : S_ERR;
            end
`endif
            S_DONE, S_ERR: begin
                if (!load_en) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_idx_nxt     = (r_state == S_HI && w_accept) ? w_idx_inc : r_idx;
    assign w_next_active = (w_next == S_COUNT) || (w_next == S_LO) ||
                           (w_next == S_HI)    || (w_next == S_CSUM);
    // Not ready on the first cycle after leaving IDLE, nor while HI is only
    // waiting for the final write to be presented.
    assign w_ready_nxt   = (r_state != S_IDLE) && w_next_active &&
                           !((w_next == S_HI) && (w_idx_nxt == r_count));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_idx     <= '0;
            r_lo      <= '0;
            r_ready   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_hold    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef PRAM_LOADER_CSUM_EN
            r_csum    <= '0;
`endif
        end else begin
            r_state <= w_next;
            r_ready <= w_ready_nxt;
            r_hold  <= w_next_active || (w_next == S_ERR);
            r_done  <= (w_next == S_DONE);
            r_err   <= (w_next == S_ERR);
            r_wr_en <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (load_en) begin
                        r_idx <= '0;
`ifdef PRAM_LOADER_CSUM_EN
                        r_csum <= '0;
`endif
                    end
                end
                S_COUNT: begin
                    if (w_accept && !w_count_bad) r_count <= byte_in[AW:0];
                end
                S_LO: begin
                    if (w_accept) begin
                        r_lo <= byte_in;
`ifdef PRAM_LOADER_CSUM_EN
                        r_csum <= r_csum ^ byte_in;
`endif
                    end
                end
                S_HI: begin
                    if (w_accept) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_idx[AW-1:0];
                        r_wr_data <= {byte_in, r_lo};
                        r_idx     <= w_idx_inc;
`ifdef PRAM_LOADER_CSUM_EN
                        r_csum    <= r_csum ^ byte_in;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign byte_ready = r_ready;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign cpu_hold   = r_hold;
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pram_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pram_loader
//  Purpose  : Self-checking bench for pram_loader. Expected RAM writes are
//             queued when the high byte of a word is issued; a monitor pops
//             and compares on every wr_en. Outcome flags are checked by the
//             stimulus process. Works with or without PRAM_LOADER_CSUM_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pram_loader;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_en = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          cpu_hold;
    logic          done;
    logic          err;

    pram_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (load_en),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] dat[$];
    int         total = 0;
    int         bad   = 0;

    // Scoreboard monitor: every write strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write got @%0d=%h required none", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.a !== wr_addr || mon_e.d !== wr_data) begin
                    bad++;
                    $display("FAIL write got @%0d=%h required @%0d=%h",
                             wr_addr, wr_data, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got %0h required %0h", name, act, req);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int n;
        repeat ($urandom_range(0, 2)) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_in    = b;
        n = 0;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            total++;
            bad++;
            $display("FAIL byte_timeout got ready=0 required ready=1 for byte %h", b);
            byte_valid = 1'b0;
            return;
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Issue a whole load: count byte n, data bytes from dat, optional checksum.
    // abort_after >= 0 drops load_en once that many data bytes were sent.
    task automatic run_load(input int n, input int abort_after, input bit bad_csum);
        logic [7:0] cs;
        wr_t        w;
        bit         aborted;
        cs = 8'h00;
        foreach (dat[i]) cs ^= dat[i];
        aborted = 1'b0;
        load_en = 1'b1;
        send_byte(8'(n));
        if (n < 1 || n > DEPTH) begin
            check("err_bad_count", err, 1);
            check("done_bad_count", done, 0);
            check("hold_in_err", cpu_hold, 1);
            repeat (3) @(negedge clk);
            check("ready_in_err", byte_ready, 0);
            check("err_held", err, 1);
        end else begin
            for (int i = 0; i < 2 * n; i++) begin
                if (i == abort_after) begin
                    aborted = 1'b1;
                    break;
                end
                if (i % 2 == 1) begin
                    w.a = AW'(i / 2);
                    w.d = {dat[i], dat[i-1]};
                    exp_q.push_back(w);
                end
                send_byte(dat[i]);
            end
            if (aborted) begin
                load_en = 1'b0;
                @(negedge clk);
                check("abort_hold", cpu_hold, 0);
                check("abort_done", done, 0);
                check("abort_err", err, 0);
                check("abort_ready", byte_ready, 0);
                repeat (4) @(negedge clk);
            end else begin
`ifdef PRAM_LOADER_CSUM_EN
                send_byte(cs ^ {7'd0, bad_csum});
                check("csum_done", done, {31'd0, !bad_csum});
                check("csum_err", err, {31'd0, bad_csum});
                check("csum_hold", cpu_hold, {31'd0, bad_csum});
                repeat (2) @(negedge clk);
                check("end_ready", byte_ready, 0);
`else
                check("last_wr", wr_en, 1);
                check("done_after_write", done, 0);
                @(negedge clk);
                check("done", done, 1);
                check("done_err", err, 0);
                check("done_hold", cpu_hold, 0);
                check("done_ready", byte_ready, 0);
`endif
            end
        end
        load_en = 1'b0;
        @(negedge clk);
        check("rel_done", done, 0);
        check("rel_err", err, 0);
        check("rel_hold", cpu_hold, 0);
        check("rel_ready", byte_ready, 0);
        check("writes_seen", exp_q.size(), 0);
    endtask

    task automatic rand_data(input int n);
        dat.delete();
        for (int k = 0; k < 2 * n; k++) dat.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        int  n;
        wr_t w;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", byte_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed two-word load: @0=1234, @1=5678, checksum 08.
        dat = '{8'h34, 8'h12, 8'h78, 8'h56};
        run_load(2, -1, 1'b0);
        // Same stream with a wrong checksum.
        run_load(2, -1, 1'b1);
        // Illegal counts.
        run_load(0, -1, 1'b0);
        run_load(33, -1, 1'b0);
        // Full depth, word k = k*0x0101.
        dat.delete();
        for (int k = 0; k < DEPTH; k++) begin
            dat.push_back(8'(k));
            dat.push_back(8'(k));
        end
        run_load(DEPTH, -1, 1'b0);
        // Abort after the third data byte, then a full load.
        rand_data(3);
        run_load(3, 3, 1'b0);
        rand_data(3);
        run_load(3, -1, 1'b0);
        // Single word.
        dat = '{8'hAA, 8'h55};
        run_load(1, -1, 1'b0);

        // Randomized loads.
        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(1, DEPTH);
            rand_data(n);
            run_load(n, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * n - 1)) : -1,
                     1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a load.
        rand_data(4);
        load_en = 1'b1;
        send_byte(8'd4);
        send_byte(dat[0]);
        w.a = '0;
        w.d = {dat[1], dat[0]};
        exp_q.push_back(w);
        send_byte(dat[1]);
        send_byte(dat[2]);
        rst_n = 1'b0;
        #1;
        check("mrst_ready", byte_ready, 0);
        check("mrst_wr_en", wr_en, 0);
        check("mrst_wr_addr", wr_addr, 0);
        check("mrst_hold", cpu_hold, 0);
        check("mrst_done", done, 0);
        check("mrst_err", err, 0);
        check("mrst_writes_seen", exp_q.size(), 0);
        load_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rand_data(5);
        run_load(5, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running required finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
